// File: rtl/key_expand_seq.sv
// key_expand_seq: sequential AES-128 key expansion, one 128-bit round key (0..NUM_ROUNDS) per rk handshake.
// Latency: round 0 valid 1 cycle after key accept; round r valid 5 cycles after the round r-1 handshake.
// Backpressure: rk_data/rk_round held while rk_valid && !rk_ready; key_ready low while busy (no queuing).
// Optional feature macro: KEY_EXPAND_ABORT_EN adds an 'abort' input that drops the engine back to IDLE.

// sub_word: AES SubWord, byte-wise S-box lookup, purely combinational.
module sub_word (
    input  logic [31:0] word,
    output logic [31:0] sub
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign sub = {SBOX[word[31:24]], SBOX[word[23:16]], SBOX[word[15:8]], SBOX[word[7:0]]};
endmodule

module key_expand_seq #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
`ifdef KEY_EXPAND_ABORT_EN
    input  logic         abort,
`endif
    input  logic [127:0] key_data,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, EMIT, CALC} state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t      state;
    logic [31:0] w0, w1, w2, w3;
    logic [7:0]  rcon;
    logic [1:0]  cnt;
    logic [31:0] rot_w3;
    logic [31:0] sub_rot_w3;
    logic [31:0] t_word;
    logic        abort_req;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // RotWord is a byte permutation, so it is done before the single S-box instance.
    assign rot_w3 = {w3[23:0], w3[31:24]};

    sub_word u_sub_word (
        .word (rot_w3),
        .sub  (sub_rot_w3)
    );

    // Only consumed on CALC counter 0; other cycles it is don't-care.
    assign t_word = sub_rot_w3 ^ {rcon, 24'h0};

`ifdef KEY_EXPAND_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Main FSM: key load, round-key emission with handshake, and 4-cycle word-serial expansion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            w0        <= '0;
            w1        <= '0;
            w2        <= '0;
            w3        <= '0;
            rcon      <= 8'h01;
            cnt       <= '0;
            rk_data   <= '0;
            rk_round  <= '0;
            rk_valid  <= 1'b0;
            key_ready <= 1'b1;
            busy      <= 1'b0;
        end else if (abort_req) begin
            // Abort wins over any handshake; word regs keep their contents.
            state     <= IDLE;
            rk_valid  <= 1'b0;
            busy      <= 1'b0;
            key_ready <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (key_valid && key_ready) begin
                        {w0, w1, w2, w3} <= key_data;
                        rk_data          <= key_data;
                        rk_round         <= '0;
                        rcon             <= 8'h01;
                        rk_valid         <= 1'b1;
                        key_ready        <= 1'b0;
                        busy             <= 1'b1;
                        state            <= EMIT;
                    end
                end
                EMIT: begin
                    if (rk_valid && rk_ready) begin
                        rk_valid <= 1'b0;
                        if (rk_round == LAST_ROUND) begin
                            state     <= IDLE;
                            key_ready <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state <= CALC;
                            cnt   <= '0;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 2'd1;
                    unique case (cnt)
                        2'd0: w0 <= w0 ^ t_word;
                        2'd1: w1 <= w1 ^ w0;
                        2'd2: w2 <= w2 ^ w1;
                        2'd3: begin
                            w3       <= w3 ^ w2;
                            // Output register captures the finished key on entry to EMIT.
                            rk_data  <= {w0, w1, w2, w3 ^ w2};
                            rk_round <= rk_round + 4'd1;
                            rcon     <= xtime(rcon);
                            rk_valid <= 1'b1;
                            state    <= EMIT;
                        end
                        default: ;
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_expand_seq.sv
// tb_key_expand_seq: checks key_expand_seq against an FIPS-197 style key-expansion model.
// The S-box is derived from GF(2^8) inversion plus the affine map.
// Inputs driven and outputs sampled on the falling edge.
module tb_key_expand_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_data;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
`ifdef KEY_EXPAND_ABORT_EN
    logic         abort;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] model_rk [11];

    key_expand_seq dut (
        .clk       (clk),
        .rst       (rst),
`ifdef KEY_EXPAND_ABORT_EN
        .abort     (abort),
`endif
        .key_data  (key_data),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_data   (rk_data),
        .rk_round  (rk_round),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] xb  = 8'(x);
            for (int y = 1; y < 256; y++)
                if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic build_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drive one key for one cycle; returns at the falling edge after the accept edge.
    task automatic send_key(input logic [127:0] k);
        key_data  = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Count falling edges until rk_valid, bounded; -1 on timeout.
    task automatic wait_valid(output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!rk_valid && gap < 40);
        if (!rk_valid) gap = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        n_tests++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_key_ready got=%b exp=1", key_ready); end
        n_tests++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rk_valid got=%b exp=0", rk_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (rk_data !== 128'h0) begin n_fail++; $display("FAIL reset_rk_data got=%h exp=0", rk_data); end
        n_tests++; if (rk_round !== 4'd0) begin n_fail++; $display("FAIL reset_rk_round got=%0d exp=0", rk_round); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_key(rand_key());
        // mid-cycle asynchronous reset while round 0 is being offered
        #2 rst = 1'b1;
        #1;
        n_tests++; if (rk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1 || rk_data !== 128'h0)
            begin n_fail++; $display("FAIL async_reset valid=%b busy=%b ready=%b data=%h exp 0/0/1/0", rk_valid, busy, key_ready, rk_data); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fips();
        int gap;
        logic [127:0] k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        build_model(k);
        rk_ready = 1'b1;
        n_tests++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL fips_idle_ready got=%b exp=1", key_ready); end
        send_key(k);
        for (int r = 0; r <= 10; r++) begin
            n_tests++; if (rk_valid !== 1'b1 || rk_round !== 4'(r))
                begin n_fail++; $display("FAIL fips_round valid=%b round=%0d exp valid=1 round=%0d", rk_valid, rk_round, r); end
            n_tests++; if (rk_data !== model_rk[r]) begin n_fail++; $display("FAIL fips_data r=%0d got=%h exp=%h", r, rk_data, model_rk[r]); end
            if (r == 0) begin n_tests++; if (rk_data !== k) begin n_fail++; $display("FAIL fips_rk0 got=%h exp=%h", rk_data, k); end end
            if (r == 1) begin n_tests++; if (rk_data !== 128'ha0fafe1788542cb123a339392a6c7605) begin n_fail++; $display("FAIL fips_rk1 got=%h exp=a0fafe1788542cb123a339392a6c7605", rk_data); end end
            if (r == 10) begin n_tests++; if (rk_data !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_fail++; $display("FAIL fips_rk10 got=%h exp=d014f9a8c9ee2589e13f0cc8b6630ca6", rk_data); end end
            if (r < 10) begin
                wait_valid(gap);
                n_tests++; if (gap != 5) begin n_fail++; $display("FAIL fips_latency r=%0d got=%0d exp=5", r + 1, gap); end
            end
        end
        @(negedge clk);
        n_tests++; if (key_ready !== 1'b1 || busy !== 1'b0 || rk_valid !== 1'b0)
            begin n_fail++; $display("FAIL fips_done ready=%b busy=%b valid=%b exp 1/0/0", key_ready, busy, rk_valid); end
    endtask

    task automatic test_backpressure();
        int gap;
        logic [127:0] k = rand_key();
        build_model(k);
        rk_ready = 1'b1;
        send_key(k);
        for (int r = 0; r <= 10; r++) begin
            n_tests++; if (rk_round !== 4'(r) || rk_data !== model_rk[r])
                begin n_fail++; $display("FAIL bp_data r=%0d got round=%0d data=%h exp=%h", r, rk_round, rk_data, model_rk[r]); end
            if (r == 3) begin
                rk_ready = 1'b0;
                for (int i = 0; i < 7; i++) begin
                    @(negedge clk);
                    n_tests++; if (rk_valid !== 1'b1 || rk_round !== 4'd3 || rk_data !== model_rk[3])
                        begin n_fail++; $display("FAIL bp_hold i=%0d valid=%b round=%0d data=%h exp round 3 data=%h", i, rk_valid, rk_round, rk_data, model_rk[3]); end
                end
                rk_ready = 1'b1;
            end
            if (r < 10) begin
                wait_valid(gap);
                n_tests++; if (gap != 5) begin n_fail++; $display("FAIL bp_latency r=%0d got=%0d exp=5", r + 1, gap); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_busy_reject();
        int gap;
        logic [127:0] k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        build_model(k);
        rk_ready = 1'b1;
        send_key(k);
        for (int r = 0; r <= 10; r++) begin
            if (r == 2) begin
                key_data  = rand_key();
                key_valid = 1'b1;
                n_tests++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL busy_key_ready got=%b exp=0", key_ready); end
            end
            n_tests++; if (rk_round !== 4'(r) || rk_data !== model_rk[r])
                begin n_fail++; $display("FAIL busy_data r=%0d got round=%0d data=%h exp=%h", r, rk_round, rk_data, model_rk[r]); end
            if (r < 10) begin
                wait_valid(gap);
                key_valid = 1'b0;
                n_tests++; if (gap != 5) begin n_fail++; $display("FAIL busy_latency r=%0d got=%0d exp=5", r + 1, gap); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_calc();
        int gap;
        int seen = 0;
        logic [127:0] k = 128'h000102030405060708090a0b0c0d0e0f;
        rk_ready = 1'b1;
        send_key(rand_key());
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++; if (rk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1 || rk_data !== 128'h0 || rk_round !== 4'd0)
            begin n_fail++; $display("FAIL calc_reset valid=%b busy=%b ready=%b round=%0d data=%h", rk_valid, busy, key_ready, rk_round, rk_data); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rk_valid) seen++;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL calc_reset_no_emit got=%0d valid cycles exp=0", seen); end
        build_model(k);
        send_key(k);
        for (int r = 0; r <= 10; r++) begin
            n_tests++; if (rk_valid !== 1'b1 || rk_round !== 4'(r) || rk_data !== model_rk[r])
                begin n_fail++; $display("FAIL newkey_data r=%0d got round=%0d data=%h exp=%h", r, rk_round, rk_data, model_rk[r]); end
            if (r == 1) begin n_tests++; if (rk_data !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe) begin n_fail++; $display("FAIL newkey_rk1 got=%h exp=d6aa74fdd2af72fadaa678f1d6ab76fe", rk_data); end end
            if (r == 10) begin n_tests++; if (rk_data !== 128'h13111d7fe3944a17f307a78b4d2b30c5) begin n_fail++; $display("FAIL newkey_rk10 got=%h exp=13111d7fe3944a17f307a78b4d2b30c5", rk_data); end end
            if (r < 10) wait_valid(gap);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            int  exp_round = 0;
            int  cyc = 0;
            bit  done = 0;
            logic [127:0] k = rand_key();
            build_model(k);
            rk_ready = 1'b0;
            send_key(k);
            while (!done && cyc < 600) begin
                if (rk_valid) begin
                    n_tests++; if (rk_round !== 4'(exp_round) || rk_data !== model_rk[exp_round])
                        begin n_fail++; $display("FAIL rand_data key=%0d r=%0d got round=%0d data=%h exp=%h", n, exp_round, rk_round, rk_data, model_rk[exp_round]); end
                end
                rk_ready = ($urandom_range(0, 2) != 0);
                if (rk_valid && rk_ready) begin
                    if (exp_round == 10) done = 1;
                    else exp_round++;
                end
                @(negedge clk);
                cyc++;
            end
            n_tests++; if (!done || key_ready !== 1'b1)
                begin n_fail++; $display("FAIL rand_complete key=%0d done=%0d ready=%b exp done=1 ready=1", n, done, key_ready); end
        end
    endtask

`ifdef KEY_EXPAND_ABORT_EN
    task automatic test_abort();
        int gap;
        int seen = 0;
        logic [127:0] k = rand_key();
        build_model(k);
        rk_ready = 1'b1;
        send_key(k);
        for (int r = 0; r < 5; r++) wait_valid(gap);
        n_tests++; if (rk_round !== 4'd5) begin n_fail++; $display("FAIL abort_pre_round got=%0d exp=5", rk_round); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_tests++; if (rk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1)
            begin n_fail++; $display("FAIL abort_state valid=%b busy=%b ready=%b exp 0/0/1", rk_valid, busy, key_ready); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rk_valid) seen++;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_round6 got=%0d valid cycles exp=0", seen); end
        abort     = 1'b1;
        key_data  = k;
        key_valid = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        key_valid = 1'b0;
        n_tests++; if (rk_valid !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL abort_idle_accept valid=%b busy=%b exp 0/0", rk_valid, busy); end
        send_key(k);
        n_tests++; if (rk_valid !== 1'b1 || rk_round !== 4'd0 || rk_data !== model_rk[0])
            begin n_fail++; $display("FAIL abort_new_rk0 got round=%0d data=%h exp=%h", rk_round, rk_data, model_rk[0]); end
        wait_valid(gap);
        n_tests++; if (gap != 5 || rk_data !== model_rk[1])
            begin n_fail++; $display("FAIL abort_new_rk1 gap=%0d data=%h exp gap=5 data=%h", gap, rk_data, model_rk[1]); end
        for (int r = 2; r <= 10; r++) wait_valid(gap);
        @(negedge clk);
    endtask
`endif

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_data  = '0;
        rk_ready  = 1'b0;
`ifdef KEY_EXPAND_ABORT_EN
        abort     = 1'b0;
`endif
        build_sbox();
        test_reset();
        test_fips();
        test_backpressure();
        test_busy_reject();
        test_reset_mid_calc();
        test_random();
`ifdef KEY_EXPAND_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
